// File: rtl/apb_modport_pkg.sv
// Shared types and constants for the APB master/slave pair.
// APB_WAIT_STATE_EN (optional macro) adds one wait state per slave access.
package apb_modport_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int SLAVE_DEPTH    = 128;
  localparam int SLAVE_IDX_W    = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// APB slave with a 128-entry register file; pslverr is never raised.
// APB_WAIT_STATE_EN defined: pready is low in the first ACCESS cycle.
module apb_slave
  import apb_modport_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [SLAVE_IDX_W-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr
);

  logic [DATA_WIDTH-1:0] r_mem [SLAVE_DEPTH];

`ifdef APB_WAIT_STATE_EN
  logic r_wait_done;

  // Toggle high after the first ACCESS cycle so the second one completes
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait_done <= 1'b0;
    end else begin
      r_wait_done <= psel && penable && !r_wait_done;
    end
  end

  assign pready = r_wait_done;
`else
  assign pready = 1'b1;
`endif

  // Commit a write on the edge that ends a ready ACCESS cycle
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < SLAVE_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (psel && penable && pready && pwrite) begin
      r_mem[paddr] <= pwdata;
    end
  end

  // Read data is combinational; the master registers it at completion
  assign prdata  = r_mem[paddr];
  assign pslverr = 1'b0;

endmodule

// File: rtl/apb_modport.sv
// APB master FSM driving two apb_slave instances selected by paddr[7].
// Request inputs pass through one register stage, so a request sampled
// at edge N reaches SETUP after N+1 and completes at N+3 (N+4 when
// APB_WAIT_STATE_EN is defined).
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic [DATA_WIDTH-1:0] apb_read_data_out
);

  // sampled request
  logic                  r_transfer;
  logic                  r_read_write;
  logic [ADDR_WIDTH-1:0] r_wr_paddr;
  logic [ADDR_WIDTH-1:0] r_rd_paddr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  // APB bus state
  apb_state_e            r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic                  w_req_pwrite;
  logic [ADDR_WIDTH-1:0] w_req_paddr;
  logic                  w_psel1;
  logic                  w_psel2;
  logic [DATA_WIDTH-1:0] w_prdata1;
  logic [DATA_WIDTH-1:0] w_prdata2;
  logic                  w_pready1;
  logic                  w_pready2;
  logic                  w_pslverr1;
  logic                  w_pslverr2;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pready;
  logic                  w_unused_pslverr;

  // Capture the request inputs every edge
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_transfer   <= 1'b0;
      r_read_write <= 1'b0;
      r_wr_paddr   <= '0;
      r_rd_paddr   <= '0;
      r_wr_data    <= '0;
    end else begin
      r_transfer   <= transfer;
      r_read_write <= READ_WRITE;
      r_wr_paddr   <= apb_write_paddr;
      r_rd_paddr   <= apb_read_paddr;
      r_wr_data    <= apb_write_data;
    end
  end

  assign w_req_pwrite = !r_read_write;
  assign w_req_paddr  = r_read_write ? r_rd_paddr : r_wr_paddr;

  // Master FSM; address/data/direction are loaded on entry to SETUP and
  // held untouched through ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_transfer) begin
            r_state   <= SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_req_pwrite;
            r_paddr   <= w_req_paddr;
            r_pwdata  <= r_wr_data;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_pready) begin
            if (!r_pwrite) begin
              r_read_data <= w_prdata;
            end
            if (r_transfer) begin
              r_state   <= SETUP;
              r_penable <= 1'b0;
              r_pwrite  <= w_req_pwrite;
              r_paddr   <= w_req_paddr;
              r_pwdata  <= r_wr_data;
            end else begin
              r_state   <= IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // Slave decode on the top address bit
  assign w_psel1 = r_psel && !r_paddr[7];
  assign w_psel2 = r_psel &&  r_paddr[7];

  apb_slave #(.DATA_WIDTH(DATA_WIDTH)) u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (w_psel1),
    .penable (r_penable),
    .pwrite  (r_pwrite),
    .paddr   (r_paddr[6:0]),
    .pwdata  (r_pwdata),
    .prdata  (w_prdata1),
    .pready  (w_pready1),
    .pslverr (w_pslverr1)
  );

  apb_slave #(.DATA_WIDTH(DATA_WIDTH)) u_slave2 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (w_psel2),
    .penable (r_penable),
    .pwrite  (r_pwrite),
    .paddr   (r_paddr[6:0]),
    .pwdata  (r_pwdata),
    .prdata  (w_prdata2),
    .pready  (w_pready2),
    .pslverr (w_pslverr2)
  );

  assign w_prdata = r_paddr[7] ? w_prdata2 : w_prdata1;
  assign w_pready = r_paddr[7] ? w_pready2 : w_pready1;

  // Error responses are not acted on by this master
  assign w_unused_pslverr = w_pslverr1 | w_pslverr2;

  assign apb_read_data_out = r_read_data;

endmodule

// File: tb/tb_apb_modport.sv
// Scoreboard bench for apb_modport; expected read data is queued when a
// read is driven and compared at the completion edge.
// Build with APB_WAIT_STATE_EN defined to exercise the wait-state timing.
module tb_apb_modport;
  import apb_modport_pkg::*;

`ifdef APB_WAIT_STATE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       pclk;
  logic       presetn;
  logic       transfer;
  logic       READ_WRITE;
  logic [7:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  int         n_checks;
  int         n_fail;
  logic [7:0] sb_q [$];
  logic [7:0] last_out;

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("check %s ok val=0x%0h", tag, got);
    end
  endtask

  // One isolated transfer; inputs are scrambled after sampling to show
  // the bus values stay latched
  task automatic xfer(input bit rd, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp, input string tag);
    logic [7:0] prev;
    logic [7:0] e;
    @(negedge pclk);
    transfer        = 1'b1;
    READ_WRITE      = rd;
    apb_write_paddr = rd ? ~addr : addr;
    apb_read_paddr  = rd ? addr : ~addr;
    apb_write_data  = wd;
    if (rd) sb_q.push_back(exp);
    prev = last_out;
    @(posedge pclk);
    @(negedge pclk);
    transfer        = 1'b0;
    READ_WRITE      = ~rd;
    apb_write_paddr = addr ^ 8'h80;
    apb_read_paddr  = addr ^ 8'h81;
    apb_write_data  = ~wd;
    repeat (LAT - 1) @(posedge pclk);
    #1;
    check_val({tag, "_early"}, 32'(apb_read_data_out), 32'(prev));
    @(posedge pclk);
    #1;
    if (rd) begin
      e = sb_q.pop_front();
      check_val(tag, 32'(apb_read_data_out), 32'(e));
      last_out = e;
    end else begin
      check_val({tag, "_hold"}, 32'(apb_read_data_out), 32'(prev));
    end
  endtask

  // Write 0x10=0x11 followed directly by a read of 0x10
  task automatic back_to_back();
    int         nidle;
    logic [7:0] prev;
    logic [7:0] e;
    nidle = 0;
    @(negedge pclk);
    transfer        = 1'b1;
    READ_WRITE      = 1'b0;
    apb_write_paddr = 8'h10;
    apb_write_data  = 8'h11;
    apb_read_paddr  = 8'h90;
    sb_q.push_back(8'h11);
    prev = last_out;
    @(posedge pclk);
    for (int ei = 1; ei <= 2 * LAT - 1; ei++) begin
      @(posedge pclk);
      #1;
      if (ei <= 2 * LAT - 2 && dut.r_state == IDLE) nidle++;
      if (ei == 2 * LAT - 2) check_val("b2b_early", 32'(apb_read_data_out), 32'(prev));
      if (ei == 2 * LAT - 1) begin
        e = sb_q.pop_front();
        check_val("b2b_read", 32'(apb_read_data_out), 32'(e));
        last_out = e;
      end
      @(negedge pclk);
      if (ei == LAT - 2) begin
        READ_WRITE      = 1'b1;
        apb_read_paddr  = 8'h10;
        apb_write_paddr = 8'h90;
        apb_write_data  = 8'hEE;
      end
      if (ei == LAT - 1) transfer = 1'b0;
    end
    check_val("b2b_no_idle", 32'(nidle), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    last_out        = 8'h00;
    presetn         = 1'b0;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_write_paddr = 8'h00;
    apb_write_data  = 8'h00;
    apb_read_paddr  = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check_val("reset_out", 32'(apb_read_data_out), 32'h00);
    check_val("reset_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge pclk);
    presetn = 1'b1;

    xfer(1'b1, 8'h7F, 8'h00, 8'h00, "rd_7f_fresh");
    xfer(1'b0, 8'h05, 8'hA5, 8'h00, "wr_05");
    xfer(1'b1, 8'h05, 8'h00, 8'hA5, "rd_05");
    xfer(1'b0, 8'h85, 8'h3C, 8'h00, "wr_85");
    xfer(1'b1, 8'h85, 8'h00, 8'h3C, "rd_85");
    xfer(1'b1, 8'h05, 8'h00, 8'hA5, "rd_05_iso");
    xfer(1'b1, 8'h7F, 8'h00, 8'h00, "rd_7f_zero");
    xfer(1'b0, 8'h00, 8'h01, 8'h00, "wr_00");
    xfer(1'b0, 8'hFF, 8'hFE, 8'h00, "wr_ff");
    xfer(1'b1, 8'hFF, 8'h00, 8'hFE, "rd_ff");
    xfer(1'b1, 8'h00, 8'h00, 8'h01, "rd_00");
    xfer(1'b1, 8'h80, 8'h00, 8'h00, "rd_80_zero");

    back_to_back();

    // Abort a write with reset asserted during its SETUP cycle
    @(negedge pclk);
    transfer        = 1'b1;
    READ_WRITE      = 1'b0;
    apb_write_paddr = 8'h20;
    apb_write_data  = 8'hFF;
    @(posedge pclk);
    @(negedge pclk);
    transfer = 1'b0;
    @(posedge pclk);
    #2;
    check_val("pre_rst_state", 32'(dut.r_state), 32'(SETUP));
    presetn = 1'b0;
    #1;
    check_val("rst_mid_out", 32'(apb_read_data_out), 32'h00);
    check_val("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
    repeat (2) @(posedge pclk);
    #1;
    check_val("rst_hold_out", 32'(apb_read_data_out), 32'h00);
    @(negedge pclk);
    presetn  = 1'b1;
    last_out = 8'h00;

    xfer(1'b1, 8'h20, 8'h00, 8'h00, "rd_20_aborted");
    xfer(1'b0, 8'h7E, 8'h5A, 8'h00, "wr_7e");
    xfer(1'b1, 8'h7E, 8'h00, 8'h5A, "rd_7e");
    xfer(1'b1, 8'h05, 8'h00, 8'h00, "rd_05_cleared");
    xfer(1'b1, 8'h85, 8'h00, 8'h00, "rd_85_cleared");

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_modport.md
APB_MODPORT -- requirements
Module: apb_modport

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, address width of both request ports.
REQ-002 Parameter: DATA_WIDTH, default 8, width of the data ports.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 pclk  input  1  rising-edge clock for all state.
REQ-005 presetn  input  1  asynchronous active-low reset.
REQ-006 transfer  input  1  request strobe, sampled at the rising edge of pclk.
REQ-007 READ_WRITE  input  1  1 = read, 0 = write; sampled with transfer.
REQ-008 apb_write_paddr  input  ADDR_WIDTH  write address.
REQ-009 apb_write_data  input  DATA_WIDTH  write data.
REQ-010 apb_read_paddr  input  ADDR_WIDTH  read address.
REQ-011 apb_read_data_out  output  DATA_WIDTH  registered read result.

Function
REQ-012 The block SHALL contain an APB master FSM and two APB slaves, each slave holding 128 x DATA_WIDTH registers.
REQ-013 FSM states are IDLE, SETUP and ACCESS.
- IDLE -> SETUP when transfer=1.
- SETUP -> ACCESS unconditionally.
- ACCESS with pready=1 -> SETUP if transfer=1, otherwise IDLE.
- ACCESS with pready=0 -> stays in ACCESS.
REQ-014 In SETUP the master SHALL latch the following:
- pwrite = !READ_WRITE.
- paddr = READ_WRITE ? apb_read_paddr : apb_write_paddr.
- pwdata = apb_write_data.
REQ-015 Address, data and direction SHALL remain stable through ACCESS; input changes during ACCESS are ignored.
REQ-016 Slave select: paddr[7]=0 selects slave 1 and paddr[7]=1 selects slave 2; paddr[6:0] indexes the register.
REQ-017 psel is asserted in SETUP and ACCESS; penable is asserted in ACCESS only.
REQ-018 A write SHALL commit to the selected slave at the rising edge ending ACCESS with pready=1.
REQ-019 A read SHALL load prdata into apb_read_data_out at that same edge.
REQ-020 apb_read_data_out SHALL hold its value until the next completed read.
REQ-021 Without wait states, transfer=1 sampled at edge N gives the following timing:
- SETUP after edge N+1.
- ACCESS after edge N+2.
- Completion at edge N+3.
REQ-022 Back-to-back transfers SHALL proceed with no IDLE cycle between them.
REQ-023 Slaves SHALL drive pslverr=0 always; the master ignores pslverr.

Reset
REQ-024 presetn=0 SHALL immediately force the following, regardless of pclk:
- FSM to IDLE.
- psel, penable and pwrite to 0.
- paddr, pwdata and apb_read_data_out to 0.
- All slave registers to 0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer; an uncompleted write SHALL NOT commit.
REQ-026 The first transfer after reset release is sampled at the first rising edge with presetn=1.

Configuration
REQ-027 Macro APB_WAIT_STATE_EN defined: each slave SHALL drive pready=0 in the first ACCESS cycle and 1 in the second, so completion occurs at edge N+4.
REQ-028 APB_WAIT_STATE_EN undefined: pready SHALL be tied to 1, giving completion at edge N+3.

Structure
REQ-029 Package apb_modport_pkg SHALL hold the following:
- The state enum (IDLE, SETUP, ACCESS).
- ADDR_WIDTH and DATA_WIDTH defaults.
- The slave depth constant (128).
REQ-030 Sub-module apb_slave SHALL be instantiated twice, with the slave select decoded in apb_modport.

Verification
REQ-031 Write then read, slave 1: write addr 0x05 data 0xA5, then read 0x05 -> apb_read_data_out=0xA5 at edge N+3 of the read.
REQ-032 Slave 2 isolation: write 0x85=0x3C and 0x05=0xA5 -> read 0x85 returns 0x3C and read 0x05 returns 0xA5.
REQ-033 Back-to-back: transfer held at 1 for write 0x10=0x11, then read 0x10 -> the FSM never enters IDLE and the read returns 0x11.
REQ-034 Reset mid-write: presetn=0 during SETUP of write 0x20=0xFF -> later read of 0x20 returns 0x00, and apb_read_data_out=0x00 during reset.
REQ-035 APB_WAIT_STATE_EN defined: read of 0x05 holding 0xA5 -> ACCESS lasts 2 cycles and data appears at edge N+4.
REQ-036 Unwritten location: read 0x7F after reset -> 0x00.
